keygen_arbiter: RTL and testbench
=================================

KEYGEN_ARBITER -- requirements
Module: keygen_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4096, range 2..65535; maximum cycles spent waiting for kg_finish after a launch.
REQ-002 SHALL have ports:
  clk  in  1  single clock; all logic on posedge clk.
  rst  in  1  synchronous, active-high reset.
  req0_valid  in  1  requester 0 has a p/q pair pending.
  req0_p, req0_q  in  8 each  requester 0 operands.
  req0_ready  out  1  one-cycle accept strobe to requester 0.
  rsp0_valid  out  1  one-cycle response strobe to requester 0.
  rsp0_e  out  8  result e for requester 0.
  rsp0_err  out  1  result invalid (rejected or timed out).
  req1_valid, req1_p, req1_q, req1_ready, rsp1_valid, rsp1_e, rsp1_err: same as requester 0, for requester 1.
  kg_start  out  1  one-cycle start pulse to the KeyGen datapath.
  kg_p, kg_q  out  8 each  operands to KeyGen.
  kg_e  in  8  KeyGen result.
  kg_finish  in  1  KeyGen completion.
  busy  out  1  high whenever state != IDLE.
  grant_id  out  1  index of the requester currently owning KeyGen.

Function
REQ-003 SHALL implement FSM states IDLE, LAUNCH, WAIT, RESP.
REQ-004 IDLE: if no reqX_valid, stay; otherwise grant one requester, assert its reqX_ready for exactly that cycle, capture its p/q and set grant_id.
REQ-005 Arbitration SHALL be round-robin: on contention, grant the requester not served last; after reset requester 0 has priority.
REQ-006 On grant, if captured p<2 or q<2, next state SHALL be RESP with err=1, e=0, and no kg_start; otherwise next state LAUNCH.
REQ-007 LAUNCH: kg_start=1 for exactly one cycle with kg_p/kg_q = captured values; next state WAIT, wait counter cleared to 0.
REQ-008 kg_p and kg_q SHALL be 0 in every cycle except LAUNCH.
REQ-009 WAIT: if kg_finish=1, capture kg_e, err=0, go to RESP; else if counter==TIMEOUT-1, set e=0, err=1, go to RESP; else increment counter.
REQ-010 kg_finish and the timeout condition in the same cycle: finish SHALL win (err=0, e=kg_e).
REQ-011 The 16-bit wait counter SHALL never wrap; WAIT lasts at most TIMEOUT cycles.
REQ-012 RESP: assert rspX_valid for grant_id only, for exactly one cycle, with rspX_e/rspX_err; mark grant_id as last served; next state IDLE.
REQ-013 rspX_e/rspX_err SHALL be 0 whenever rspX_valid=0.
REQ-014 kg_finish SHALL be ignored in IDLE, LAUNCH and RESP.
REQ-015 Latency: finish sampled in WAIT at cycle F -> rsp valid at F+1; accept at T -> kg_start at T+1.
REQ-016 A new request SHALL not be accepted until the FSM is back in IDLE (one KeyGen operation in flight at most).
REQ-017 reqX_valid dropping after accept SHALL not affect the operation in flight.

Reset
REQ-018 With rst=1 at a posedge: state=IDLE, counter=0, captured p/q/e=0, last-served pointer set so requester 0 wins first.
REQ-019 Every output SHALL be 0 on the cycle after rst is sampled high, including mid-operation (LAUNCH/WAIT/RESP); the aborted response is never issued.

Verification
REQ-020 req0 p=34,q=12 accepted at T -> kg_start at T+1 with kg_p=34,kg_q=12; model finish with kg_e=5 at T+6 -> rsp0_valid at T+7, rsp0_e=5, rsp0_err=0, busy low at T+8.
REQ-021 After reset, req0 and req1 valid continuously -> grants alternate 0,1,0,1; rsp1 never asserted while grant_id=0.
REQ-022 TIMEOUT=16, kg_start at L, kg_finish held 0 -> rsp valid at L+17 with err=1, e=0.
REQ-023 req1 p=1,q=13 -> req1_ready at T, no kg_start, rsp1_valid at T+1 with err=1, e=0.
REQ-024 rst pulsed during WAIT -> all outputs 0 next cycle; kg_finish pulsed afterwards in IDLE -> no rsp.
REQ-025 TIMEOUT=16, kg_finish=1 with kg_e=7 in the final WAIT cycle -> rsp err=0, e=7.

Source files
------------

// File: rtl/keygen_arbiter.sv
// Two-requester round-robin front end for a single KeyGen datapath.
// One operation in flight. Operands below 2 are rejected without starting KeyGen.
module keygen_arbiter #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_p,
  input  logic [7:0] req0_q,
  output logic       req0_ready,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_e,
  output logic       rsp0_err,
  input  logic       req1_valid,
  input  logic [7:0] req1_p,
  input  logic [7:0] req1_q,
  output logic       req1_ready,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_e,
  output logic       rsp1_err,
  output logic       kg_start,
  output logic [7:0] kg_p,
  output logic [7:0] kg_q,
  input  logic [7:0] kg_e,
  input  logic       kg_finish,
  output logic       busy,
  output logic       grant_id
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e      r_state, w_state_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic [7:0]  r_p, w_p_d;
  logic [7:0]  r_q, w_q_d;
  logic [7:0]  r_e, w_e_d;
  logic        r_err, w_err_d;
  logic        r_grant, w_grant_d;
  logic        r_last, w_last_d;
  // High for the cycle after reset so no requester is strobed while outputs must read 0.
  logic        r_hold;
  logic        w_accept;
  logic        w_pick;
  logic [7:0]  w_sel_p;
  logic [7:0]  w_sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_e     <= '0;
      r_err   <= 1'b0;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_hold  <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_p     <= w_p_d;
      r_q     <= w_q_d;
      r_e     <= w_e_d;
      r_err   <= w_err_d;
      r_grant <= w_grant_d;
      r_last  <= w_last_d;
      r_hold  <= 1'b0;
    end
  end

  // Contention goes to whoever was not served last; otherwise the lone requester.
  assign w_pick  = (req0_valid && req1_valid) ? ~r_last : ~req0_valid;
  assign w_sel_p = w_pick ? req1_p : req0_p;
  assign w_sel_q = w_pick ? req1_q : req0_q;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_p_d     = r_p;
    w_q_d     = r_q;
    w_e_d     = r_e;
    w_err_d   = r_err;
    w_grant_d = r_grant;
    w_last_d  = r_last;
    w_accept  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if ((req0_valid || req1_valid) && !r_hold && !rst) begin
          w_accept  = 1'b1;
          w_grant_d = w_pick;
          w_p_d     = w_sel_p;
          w_q_d     = w_sel_q;
          if (w_sel_p < 8'd2 || w_sel_q < 8'd2) begin
            w_e_d     = 8'd0;
            w_err_d   = 1'b1;
            w_state_d = StResp;
          end else begin
            w_state_d = StLaunch;
          end
        end
      end
      StLaunch: begin
        w_cnt_d   = '0;
        w_state_d = StWait;
      end
      StWait: begin
        if (kg_finish) begin
          w_e_d     = kg_e;
          w_err_d   = 1'b0;
          w_state_d = StResp;
        end else if (r_cnt == TimeoutLast) begin
          w_e_d     = 8'd0;
          w_err_d   = 1'b1;
          w_state_d = StResp;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StResp: begin
        w_last_d  = r_grant;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    req0_ready = w_accept && !w_pick;
    req1_ready = w_accept && w_pick;
    rsp0_valid = (r_state == StResp) && !r_grant;
    rsp1_valid = (r_state == StResp) && r_grant;
    rsp0_e     = rsp0_valid ? r_e : 8'd0;
    rsp0_err   = rsp0_valid && r_err;
    rsp1_e     = rsp1_valid ? r_e : 8'd0;
    rsp1_err   = rsp1_valid && r_err;
    kg_start   = (r_state == StLaunch);
    kg_p       = kg_start ? r_p : 8'd0;
    kg_q       = kg_start ? r_q : 8'd0;
    busy       = (r_state != StIdle);
    grant_id   = r_grant;
  end

endmodule

// File: tb/tb_keygen_arbiter.sv
// Directed bench for keygen_arbiter with TIMEOUT=16 and hand-computed expectations.
module tb_keygen_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_p = '0, req0_q = '0, req1_p = '0, req1_q = '0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [7:0] rsp0_e, rsp1_e, kg_p, kg_q;
  logic [7:0] kg_e = '0;
  logic       kg_finish = 1'b0;
  logic       kg_start, busy, grant_id;

  int n_checks = 0;
  int n_errors = 0;

  keygen_arbiter #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_p    (req0_p),
    .req0_q    (req0_q),
    .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid),
    .rsp0_e    (rsp0_e),
    .rsp0_err  (rsp0_err),
    .req1_valid(req1_valid),
    .req1_p    (req1_p),
    .req1_q    (req1_q),
    .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid),
    .rsp1_e    (rsp1_e),
    .rsp1_err  (rsp1_err),
    .kg_start  (kg_start),
    .kg_p      (kg_p),
    .kg_q      (kg_q),
    .kg_e      (kg_e),
    .kg_finish (kg_finish),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({req0_ready, req1_ready, rsp0_valid, rsp0_e, rsp0_err, rsp1_valid, rsp1_e,
                rsp1_err, kg_start, kg_p, kg_q, busy, grant_id});
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("reset_outs", all_outs(), 64'd0);
  endtask

  // Requester 0 launches p/q; kg_finish is pulsed at L+fin_k (fin_k=0: never).
  task automatic op0(input string tag, input logic [7:0] p, input logic [7:0] q,
                     input int fin_k, input logic [7:0] fe,
                     input logic exp_err, input logic [7:0] exp_e);
    int n;
    n = (fin_k == 0) ? 16 : fin_k;
    tick();
    req0_valid = 1'b1; req0_p = p; req0_q = q;
    #1;
    check({tag, "_ready"}, req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    #1;
    check({tag, "_kg_start"}, kg_start, 1'b1);
    check({tag, "_kg_pq"}, {kg_p, kg_q}, {p, q});
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == fin_k) begin
        kg_finish = 1'b1; kg_e = fe;
      end
      #1;
      if (k == 1) check({tag, "_wait_kg_pq"}, {kg_start, kg_p, kg_q}, 64'd0);
      if (k == n) check({tag, "_no_early_rsp"}, {rsp0_valid, busy}, 2'b01);
    end
    tick();
    kg_finish = 1'b0; kg_e = 8'd0;
    #1;
    check({tag, "_rsp"}, {rsp0_valid, rsp0_err, rsp0_e, rsp1_valid}, {1'b1, exp_err, exp_e, 1'b0});
    tick();
    #1;
    check({tag, "_idle"}, {busy, rsp0_valid}, 2'b00);
  endtask

  initial begin
    tick();
    do_reset();

    // Normal operation: finish at T+6 (L+5) returns e=5.
    op0("normal", 8'd34, 8'd12, 5, 8'd5, 1'b0, 8'd5);

    // Reject on operand < 2: response next cycle, no KeyGen start.
    tick();
    req1_valid = 1'b1; req1_p = 8'd1; req1_q = 8'd13;
    #1;
    check("rej_ready", {req1_ready, req0_ready}, 2'b10);
    tick();
    req1_valid = 1'b0;
    #1;
    check("rej_no_start", kg_start, 1'b0);
    check("rej_rsp", {rsp1_valid, rsp1_err, rsp1_e, rsp0_valid}, {1'b1, 1'b1, 8'd0, 1'b0});
    tick();
    #1;
    check("rej_idle", busy, 1'b0);

    // Round robin under continuous contention, starting from reset.
    do_reset();
    tick();
    req0_valid = 1'b1; req0_p = 8'd0; req0_q = 8'd0;
    req1_valid = 1'b1; req1_p = 8'd0; req1_q = 8'd0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_ready", {req1_ready, req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      #1;
      check("rr_rsp", {grant_id, rsp1_valid, rsp0_valid},
            (i % 2 == 0) ? 3'b001 : 3'b110);
      tick();
      #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Timeout: no finish, response at L+17 with err.
    op0("timeout", 8'd3, 8'd5, 0, 8'd0, 1'b1, 8'd0);

    // Finish in the last WAIT cycle wins over timeout.
    op0("late_fin", 8'd7, 8'd11, 16, 8'd7, 1'b0, 8'd7);

    // Reset mid-WAIT aborts the operation; a later finish is ignored.
    tick();
    req0_valid = 1'b1; req0_p = 8'd34; req0_q = 8'd12;
    tick();
    req0_valid = 1'b0;
    tick();
    req1_valid = 1'b1; req1_p = 8'd9; req1_q = 8'd9;
    #1;
    check("busy_no_accept", {req1_ready, busy}, 2'b01);
    tick();
    req1_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_outs", all_outs(), 64'd0);
    tick();
    kg_finish = 1'b1; kg_e = 8'd9;
    #1;
    check("abort_fin_ignored", {rsp0_valid, rsp1_valid, busy}, 3'b000);
    tick();
    kg_finish = 1'b0; kg_e = 8'd0;
    #1;
    check("abort_no_rsp", {rsp0_valid, rsp1_valid, busy}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
